// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-fed 8N1 serial transmitter.
// Frame layout: one start bit, DATA_BITS data bits LSB first, one stop bit.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    STOP
  } state_e;

  localparam int FRAME_BITS           = 10;
  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 16;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read side plus serial line and status of the transmitter.
// The master is the transmitter; the slave is the FIFO and line environment.
interface fifo_uart_tx_if;
  logic       fifoEmpty;
  logic [7:0] fifoData;
  logic       readEn;
  logic       txOut;
  logic       busy;
  logic       txDone;

  modport master (
    input  fifoEmpty,
    input  fifoData,
    output readEn,
    output txOut,
    output busy,
    output txDone
  );

  modport slave (
    output fifoEmpty,
    output fifoData,
    input  readEn,
    input  txOut,
    input  busy,
    input  txDone
  );
endinterface

// File: rtl/fifo_uart_tx_baud_gen.sv
// Bit-period counter: ticks on count CLKS_PER_BIT-1 and wraps, held at 0 while clear.
// Tick is combinational from the count; no backpressure, free-running when not cleared.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  // Wrapping on tick restarts the period for the next bit without a clear.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a byte FIFO one entry per frame and sends each as 8N1, LSB first; 3 cycles fetch-to-start.
// One read strobe per frame, none while a frame is in flight; FIFO absorbs producer bursts.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic           clk,
  input  logic           reset,
  fifo_uart_tx_if.master bus
);

  state_e               state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [2:0]           bit_idx_q;
  logic                 tx_q;
  logic                 rd_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 baud_clear;
  logic                 baud_tick;

  // The bit period only runs while a frame is on the line, so every timed state starts at 0.
  assign baud_clear = !(state_q inside {START, DATA, STOP});

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .reset(reset),
    .clear(baud_clear),
    .tick (baud_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      rd_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      rd_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!bus.fifoEmpty) begin
            state_q <= FETCH;
            rd_q    <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        FETCH: begin
          state_q <= LOAD;
        end
        LOAD: begin
          shift_q <= bus.fifoData;
          tx_q    <= 1'b0;
          state_q <= START;
        end
        START: begin
          if (baud_tick) begin
            state_q   <= DATA;
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
          end
        end
        DATA: begin
          if (baud_tick) begin
            // Output is registered, so the next bit is read one position ahead of the shift.
            if (bit_idx_q == 3'(DATA_BITS - 1)) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              tx_q <= shift_q[1];
            end
            shift_q   <= shift_q >> 1;
            bit_idx_q <= bit_idx_q + 1'b1;
          end
        end
        STOP: begin
          if (baud_tick) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.readEn = rd_q;
  assign bus.txOut  = tx_q;
  assign bus.busy   = busy_q;
  assign bus.txDone = done_q;

endmodule
